down_counter_timer: RTL and testbench
=====================================

// Module: down_counter_timer
// PURPOSE
//   Loadable down-counting timer: the decrementing, one-shot counterpart to the free-running
//   up-counter (0..10 wrap). Accepts a start value over a valid/ready load port, counts down
//   to zero under an enable, and emits a one-cycle expire pulse. Used as a watchdog/delay
//   element next to the up-counters in the same clock domain.
// PARAMETERS
//   WIDTH        8      width of load value and count output
//   RESET_VALUE  0      value of io_out after reset and after abort
// PORTS
//   clock          in   1      single clock; all state updates on posedge
//   reset          in   1      synchronous, active-high reset
//   io_load_valid  in   1      load request
//   io_load_ready  out  1      high when a load can be accepted (state IDLE)
//   io_load_bits   in   WIDTH  start value N
//   io_en          in   1      count enable; low = pause (hold io_out)
//   io_abort       in   1      cancel a running count
//   io_out         out  WIDTH  current count (registered)
//   io_busy        out  1      high in state RUN
//   io_expire      out  1      registered one-cycle pulse, high in the cycle io_out becomes 0
// BEHAVIOUR
//   Reset (sync, active-high): state=IDLE, io_out=RESET_VALUE, io_expire=0, io_busy=0,
//     io_load_ready=1, reload register=0. Reset mid-RUN aborts with no expire pulse.
//   States: IDLE, RUN (2-value enum). io_load_ready=(state==IDLE); io_busy=(state==RUN).
//   IDLE: load accepted when io_load_valid&&io_load_ready.
//     N>0: next cycle io_out=N, state=RUN, reload register<=N.
//     N==0: state stays IDLE, io_out=0, io_expire=1 next cycle (zero-length timer).
//     io_abort ignored in IDLE; load+abort same cycle -> load wins.
//   RUN, priority: io_abort > decrement.
//     io_abort=1: next cycle IDLE, io_out=RESET_VALUE, io_expire=0.
//     io_en=1, io_out>1: io_out<=io_out-1.
//     io_en=1, io_out==1: io_out<=0, io_expire<=1, next state per CONFIGURATION.
//     io_en=0: io_out holds, no expire.
//   Latency: load of N accepted in cycle t with io_en held high -> io_out=N at t+1,
//     io_out=0 and io_expire=1 at t+1+N.
//   Arithmetic: WIDTH-bit unsigned; count never decrements below 0 (no underflow wrap).
//     N=2^WIDTH-1 is legal. io_expire is 0 in every cycle not listed above.
//   io_load_bits ignored unless the handshake fires; loads while RUN are not accepted.
// CONFIGURATION
//   DOWN_COUNTER_AUTORELOAD_EN defined: on io_out 1->0 state stays RUN; in RUN with
//     io_out==0 and io_en=1, io_out<=reload register (period N+1 enabled cycles, one
//     expire per period). Only io_abort or reset returns to IDLE.
//   Not defined: on io_out 1->0 state<=IDLE (one-shot); reload register unused.
// STRUCTURE
//   Shared package counter_pkg: state enum typedef (IDLE, RUN), default WIDTH constant.
//   Flat module: one state register, one count register, one reload register, one expire
//   flop; no sub-module is warranted.
// TESTING
//   1 Reset: hold reset 2 cycles -> io_out=0, io_busy=0, io_load_ready=1, io_expire=0.
//   2 Load 8'h0A, io_en=1 -> io_out 10,9..1,0; io_expire=1 exactly on cycle io_out=0,
//     11 cycles after acceptance; then IDLE, io_load_ready=1 (one-shot build).
//   3 Load 5, io_en low for 3 cycles at io_out=3 -> io_out holds 3, expire delayed 3 cycles.
//   4 Load 8'hFF, io_abort at io_out=8'hF0 -> next cycle IDLE, io_out=0, no expire pulse;
//     repeat with reset at io_out=8'h80 -> same outcome.
//   5 Load 0 -> io_expire=1 next cycle, io_busy never high; load+abort in IDLE -> load taken.
//   6 DOWN_COUNTER_AUTORELOAD_EN, load 3 -> io_out 3,2,1,0,3,2,1,0..; expire every 4 cycles;
//     io_load_valid during RUN not accepted (io_load_ready=0).

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: FSM state encoding and default datapath width.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/down_counter_timer_if.sv
// Load handshake, control and status bundle of the down-counting timer.
interface down_counter_timer_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             io_load_valid;
    logic             io_load_ready;
    logic [WIDTH-1:0] io_load_bits;
    logic             io_en;
    logic             io_abort;
    logic [WIDTH-1:0] io_out;
    logic             io_busy;
    logic             io_expire;

    modport master (
        output io_load_valid, io_load_bits, io_en, io_abort,
        input  io_load_ready, io_out, io_busy, io_expire
    );

    modport slave (
        input  io_load_valid, io_load_bits, io_en, io_abort,
        output io_load_ready, io_out, io_busy, io_expire
    );

endinterface

// File: rtl/down_counter_timer.sv
// Loadable one-shot down-counting timer with a one-cycle expire pulse.
// Define DOWN_COUNTER_AUTORELOAD_EN to make it periodic (reloads the start value after expiry).
module down_counter_timer
    import counter_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                clock,
    input  logic                reset,
    down_counter_timer_if.slave io
);

    state_e           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_expire;

    state_e           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_expire_nxt;
    logic             w_load_fire;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
`endif

    assign w_load_fire = io.io_load_valid && (r_state == IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= RESET_VALUE;
            r_expire <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            r_reload <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_expire <= w_expire_nxt;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            r_reload <= w_reload_nxt;
`endif
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_expire_nxt = 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        w_reload_nxt = r_reload;
`endif
        case (r_state)
            IDLE: begin
                if (w_load_fire) begin
                    if (io.io_load_bits != '0) begin
                        w_state_nxt = RUN;
                        w_count_nxt = io.io_load_bits;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                        w_reload_nxt = io.io_load_bits;
`endif
                    end else begin
                        // Zero-length timer: expire immediately without entering RUN.
                        w_count_nxt  = '0;
                        w_expire_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (io.io_abort) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = RESET_VALUE;
                end else if (io.io_en) begin
                    if (r_count > WIDTH'(1)) begin
                        w_count_nxt = r_count - WIDTH'(1);
                    end else if (r_count == WIDTH'(1)) begin
                        w_count_nxt  = '0;
                        w_expire_nxt = 1'b1;
`ifndef DOWN_COUNTER_AUTORELOAD_EN
                        w_state_nxt  = IDLE;
`endif
                    end
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                    else begin
                        // Zero count in RUN only occurs after an expiry: start the next period.
                        w_count_nxt = r_reload;
                    end
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign io.io_load_ready = (r_state == IDLE);
    assign io.io_busy       = (r_state == RUN);
    assign io.io_out        = r_count;
    assign io.io_expire     = r_expire;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer; covers the one-shot build and,
// when DOWN_COUNTER_AUTORELOAD_EN is defined, the periodic build.
module tb_down_counter_timer;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    down_counter_timer_if #(.WIDTH(8)) bus ();

    down_counter_timer #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Periodic build never leaves RUN by itself; abort to get back to IDLE.
    task automatic end_run();
        if (AUTO) begin
            bus.io_abort = 1'b1;
            tick();
            bus.io_abort = 1'b0;
        end
    endtask

    initial begin
        bus.io_load_valid = 1'b0;
        bus.io_load_bits  = 8'h00;
        bus.io_en         = 1'b0;
        bus.io_abort      = 1'b0;

        // 1: reset held two cycles
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out",    bus.io_out,        8'h00);
        chk("rst_busy",   bus.io_busy,       1'b0);
        chk("rst_ready",  bus.io_load_ready, 1'b1);
        chk("rst_expire", bus.io_expire,     1'b0);

        // 2: load 10, count to zero; a load attempt mid-run must be ignored
        bus.io_load_valid = 1'b1;
        bus.io_load_bits  = 8'h0A;
        bus.io_en         = 1'b1;
        tick();
        bus.io_load_valid = 1'b0;
        bus.io_load_bits  = 8'h55;
        chk("t2_out_n",   bus.io_out,        8'h0A);
        chk("t2_busy",    bus.io_busy,       1'b1);
        chk("t2_ready",   bus.io_load_ready, 1'b0);
        chk("t2_exp0",    bus.io_expire,     1'b0);
        for (int k = 9; k >= 1; k--) begin
            tick();
            chk("t2_out",  bus.io_out,    k);
            chk("t2_exp",  bus.io_expire, 1'b0);
            if (k == 7) begin
                bus.io_load_valid = 1'b1;
                bus.io_load_bits  = 8'h03;
            end else begin
                bus.io_load_valid = 1'b0;
            end
        end
        tick();
        chk("t2_out_z",   bus.io_out,        8'h00);
        chk("t2_expire",  bus.io_expire,     1'b1);
        chk("t2_busy_z",  bus.io_busy,       AUTO);
        chk("t2_ready_z", bus.io_load_ready, !AUTO);
        end_run();
        tick();
        chk("t2_exp_off", bus.io_expire,     1'b0);
        chk("t2_idle",    bus.io_load_ready, 1'b1);

        // 3: load 5, pause three cycles at 3
        bus.io_load_valid = 1'b1;
        bus.io_load_bits  = 8'h05;
        tick();
        bus.io_load_valid = 1'b0;
        chk("t3_out5", bus.io_out, 8'h05);
        tick();
        chk("t3_out4", bus.io_out, 8'h04);
        tick();
        chk("t3_out3", bus.io_out, 8'h03);
        bus.io_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold",     bus.io_out,    8'h03);
            chk("t3_hold_exp", bus.io_expire, 1'b0);
        end
        bus.io_en = 1'b1;
        tick();
        chk("t3_out2", bus.io_out, 8'h02);
        tick();
        chk("t3_out1", bus.io_out,    8'h01);
        chk("t3_exp1", bus.io_expire, 1'b0);
        tick();
        chk("t3_out0",   bus.io_out,    8'h00);
        chk("t3_expire", bus.io_expire, 1'b1);
        end_run();

        // 4a: load 255, abort at 0xF0
        bus.io_load_valid = 1'b1;
        bus.io_load_bits  = 8'hFF;
        tick();
        bus.io_load_valid = 1'b0;
        chk("t4_out_ff", bus.io_out, 8'hFF);
        for (int i = 0; i < 15; i++) tick();
        chk("t4_out_f0", bus.io_out, 8'hF0);
        bus.io_abort = 1'b1;
        tick();
        bus.io_abort = 1'b0;
        chk("t4_abort_out",   bus.io_out,        8'h00);
        chk("t4_abort_busy",  bus.io_busy,       1'b0);
        chk("t4_abort_ready", bus.io_load_ready, 1'b1);
        chk("t4_abort_exp",   bus.io_expire,     1'b0);
        tick();
        chk("t4_abort_exp2",  bus.io_expire,     1'b0);

        // 4b: load 255, reset at 0x80
        bus.io_load_valid = 1'b1;
        bus.io_load_bits  = 8'hFF;
        tick();
        bus.io_load_valid = 1'b0;
        for (int i = 0; i < 127; i++) tick();
        chk("t4_out_80", bus.io_out, 8'h80);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_rst_out",   bus.io_out,        8'h00);
        chk("t4_rst_busy",  bus.io_busy,       1'b0);
        chk("t4_rst_ready", bus.io_load_ready, 1'b1);
        chk("t4_rst_exp",   bus.io_expire,     1'b0);
        tick();
        chk("t4_rst_exp2",  bus.io_expire,     1'b0);

        // 5a: zero-length load; abort in IDLE without a load is a no-op
        bus.io_abort = 1'b1;
        tick();
        bus.io_abort = 1'b0;
        chk("t5_idle_abort", bus.io_load_ready, 1'b1);
        bus.io_load_valid = 1'b1;
        bus.io_load_bits  = 8'h00;
        tick();
        bus.io_load_valid = 1'b0;
        chk("t5_zero_exp",   bus.io_expire, 1'b1);
        chk("t5_zero_busy",  bus.io_busy,   1'b0);
        chk("t5_zero_out",   bus.io_out,    8'h00);
        tick();
        chk("t5_zero_exp2",  bus.io_expire, 1'b0);
        chk("t5_zero_busy2", bus.io_busy,   1'b0);

        // 5b: load and abort together in IDLE: load wins
        bus.io_load_valid = 1'b1;
        bus.io_load_bits  = 8'h02;
        bus.io_abort      = 1'b1;
        tick();
        bus.io_load_valid = 1'b0;
        bus.io_abort      = 1'b0;
        chk("t5_la_busy", bus.io_busy, 1'b1);
        chk("t5_la_out",  bus.io_out,  8'h02);
        tick();
        chk("t5_la_out1", bus.io_out,  8'h01);
        tick();
        chk("t5_la_out0", bus.io_out,    8'h00);
        chk("t5_la_exp",  bus.io_expire, 1'b1);
        end_run();

`ifdef DOWN_COUNTER_AUTORELOAD_EN
        // 6: periodic reload of 3, loads refused while running
        bus.io_load_valid = 1'b1;
        bus.io_load_bits  = 8'h03;
        tick();
        bus.io_load_valid = 1'b0;
        chk("t6_out3", bus.io_out, 8'h03);
        for (int i = 0; i < 7; i++) begin
            automatic int v = 3 - ((i + 1) % 4);
            if (i == 3) begin
                chk("t6_ready", bus.io_load_ready, 1'b0);
                bus.io_load_valid = 1'b1;
                bus.io_load_bits  = 8'h09;
            end else begin
                bus.io_load_valid = 1'b0;
            end
            tick();
            chk("t6_out",  bus.io_out,    v);
            chk("t6_exp",  bus.io_expire, (v == 0));
            chk("t6_busy", bus.io_busy,   1'b1);
        end
        bus.io_load_valid = 1'b0;
        end_run();
        chk("t6_end_idle", bus.io_load_ready, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
